// File: rtl/gen_sum_accum.sv
// rtl/gen_sum_accum.sv - windowed saturating accumulator for an adder's sum stream
module gen_sum_accum #(
  parameter int N     = 4,
  parameter int COUNT = 8,
  parameter int ACC_W = 8,
  localparam int CW   = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] acc_out,
  output logic [CW-1:0]    cnt_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready
);

  // Adder width is wide enough for both operands plus one carry bit, so any
  // bit at or above ACC_W means the true total no longer fits.
  localparam int SW = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic [SW-1:0]    sum_wide;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_sat;
  logic [CW-1:0]    cnt_inc;
  logic             take;
  logic             closing;

  // Next-value datapath: saturating add, sample count and block-close decision.
  always_comb begin
    sum_wide = SW'(acc) + SW'(sum_in);
    sat_hit  = |sum_wide[SW-1:ACC_W];
    acc_sat  = sat_hit ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_inc  = cnt + CW'(1);
    take     = in_valid && in_ready;
    // flush only closes a block that already holds samples (ACCUM); a sample
    // accepted on the same edge is folded in before the block is closed.
    closing  = (take && (cnt_inc == CW'(COUNT))) || ((state == ACCUM) && flush);
  end

  // Control FSM with registered handshake outputs and accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc <= acc_sat;
            cnt <= cnt_inc;
            ovf <= ovf | sat_hit;
          end
          if (closing) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (take) begin
            state <= ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign acc_out = acc;
  assign cnt_out = cnt;
  assign ovf_out = ovf;

endmodule
